// File: rtl/pong_pkg.sv
// Shared encodings for the pong pixel pipeline: modes, flash FSM states,
// default colour nibbles ({R,G,B}, 4 bits each) and the stage-1 region flags.
package pong_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'b00,
        MODE_HANDICAP = 2'b01,
        MODE_MONO     = 2'b10
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLASH = 1'b1
    } flash_state_e;

    typedef struct packed {
        logic wall;
        logic paddle;
        logic ball;
        logic overlay;
    } region_t;

    // NORMAL palette
    localparam logic [11:0] N_BALL   = 12'hF00;
    localparam logic [11:0] N_PADDLE = 12'h0F0;
    localparam logic [11:0] N_WALL   = 12'h00F;
    localparam logic [11:0] N_BG     = 12'hFFF;

    // HANDICAP palette
    localparam logic [11:0] H_OVL    = 12'hCE0;
    localparam logic [11:0] H_BALL   = 12'h00F;
    localparam logic [11:0] H_PADDLE = 12'h000;
    localparam logic [11:0] H_WALL   = 12'hFFF;
    localparam logic [11:0] H_BG     = 12'h3C0;

    // MONO palette
    localparam logic [11:0] M_OBJ    = 12'hFFF;
    localparam logic [11:0] M_BG     = 12'h000;

endpackage

// File: rtl/pong_pixel_pipe_if.sv
// Video-side bundle for the pixel pipe: raster position, game object
// positions and control pulses in; coloured pixel and status out.
interface pong_pixel_pipe_if #(
    parameter int CW = 4
);
    logic [9:0]      pixel_x;
    logic [9:0]      pixel_y;
    logic            video_on;
    logic            frame_start;
    logic [1:0]      mode_req;
    logic            hit;
    logic [9:0]      paddle_y;
    logic [9:0]      ball_x;
    logic [9:0]      ball_y;
    logic [3*CW-1:0] rgb;
    logic            rgb_valid;
    logic [1:0]      mode_active;
    logic            flashing;

    modport master (
        output pixel_x, pixel_y, video_on, frame_start, mode_req, hit,
               paddle_y, ball_x, ball_y,
        input  rgb, rgb_valid, mode_active, flashing
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, frame_start, mode_req, hit,
               paddle_y, ball_x, ball_y,
        output rgb, rgb_valid, mode_active, flashing
    );
endinterface

// File: rtl/pong_flash_ctrl.sv
// Paddle flash controller: a hit starts (or restarts) a flash lasting
// FLASH_FRAMES frames. A hit coinciding with frame_start reloads without
// decrementing. FLASH_FRAMES=0 disables flashing entirely.
module pong_flash_ctrl
    import pong_pkg::*;
#(
    parameter int FLASH_FRAMES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic hit,
    input  logic frame_start,
    output logic flashing
);
    localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(FLASH_FRAMES);

    flash_state_e     state, state_nxt;
    logic [CNT_W-1:0] flash_cnt, cnt_nxt;

    // State and frame counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            flash_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flash_cnt <= cnt_nxt;
        end
    end

    // Next state: hit (re)loads, frame_start counts down to IDLE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = flash_cnt;
        case (state)
            ST_IDLE: begin
                if (hit && FLASH_FRAMES != 0) begin
                    state_nxt = ST_FLASH;
                    cnt_nxt   = LOAD;
                end
            end
            ST_FLASH: begin
                if (hit) begin
                    cnt_nxt = LOAD;
                end else if (frame_start) begin
                    if (flash_cnt <= CNT_W'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = flash_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign flashing = (state == ST_FLASH);

endmodule

// File: rtl/pong_pixel_pipe.sv
// Two-stage pong pixel colouriser. Stage 1 registers the object hit flags
// and video_on; stage 2 applies the per-mode palette and paddle flash.
module pong_pixel_pipe
    import pong_pkg::*;
#(
    parameter int CW           = 4,
    parameter int PADDLE_H     = 72,
    parameter int BALL_W       = 8,
    parameter int BALL_H       = 8,
    parameter int WALL_X0      = 32,
    parameter int WALL_X1      = 35,
    parameter int PAD_X0       = 600,
    parameter int PAD_X1       = 603,
    parameter int HC_X0        = 100,
    parameter int HC_X1        = 400,
    parameter int FLASH_FRAMES = 8
) (
    input logic              clk,
    input logic              reset,
    pong_pixel_pipe_if.slave bus
);
    localparam int STAGES = 2;

    // Replicate each 4-bit nibble MSB-first across CW bits, per channel
    function automatic logic [3*CW-1:0] expand(input logic [11:0] c);
        logic [3*CW-1:0] r;
        r = '0;
        for (int ch = 0; ch < 3; ch++)
            for (int i = 0; i < CW; i++)
                r[ch*CW + CW-1-i] = c[ch*4 + 3 - (i % 4)];
        return r;
    endfunction

    logic [10:0]     px, py, ball_r, ball_b, pad_b;
    region_t         reg_d, s1;
    logic [STAGES:1] vld_pipe;
    mode_e           mode_q;
    logic            flashing;
    logic [11:0]     nib;
    logic            pad_win;
    logic [3*CW-1:0] col_d, rgb_q;

    // 11-bit bounds so object extents near column/row 1023 cannot wrap
    assign px     = {1'b0, bus.pixel_x};
    assign py     = {1'b0, bus.pixel_y};
    assign ball_r = {1'b0, bus.ball_x}   + 11'(BALL_W);
    assign ball_b = {1'b0, bus.ball_y}   + 11'(BALL_H);
    assign pad_b  = {1'b0, bus.paddle_y} + 11'(PADDLE_H);

    // Region compare, all bounds inclusive
    always_comb begin
        reg_d.wall    = (px >= 11'(WALL_X0)) && (px <= 11'(WALL_X1));
        reg_d.paddle  = (px >= 11'(PAD_X0)) && (px <= 11'(PAD_X1)) &&
                        (py >= {1'b0, bus.paddle_y}) && (py <= pad_b);
        reg_d.ball    = (px >= {1'b0, bus.ball_x}) && (px <= ball_r) &&
                        (py >= {1'b0, bus.ball_y}) && (py <= ball_b);
        reg_d.overlay = (px >= 11'(HC_X0)) && (px <= 11'(HC_X1));
    end

    // Stage 1: region flags and video_on
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1       <= '0;
            vld_pipe <= '0;
        end else begin
            s1       <= reg_d;
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.video_on};
        end
    end

    // Mode only changes at a frame boundary; the reserved code is ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mode_q <= MODE_NORMAL;
        else if (bus.frame_start && bus.mode_req != 2'b11)
            mode_q <= mode_e'(bus.mode_req);
    end

    pong_flash_ctrl #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
        .clk         (clk),
        .reset       (reset),
        .hit         (bus.hit),
        .frame_start (bus.frame_start),
        .flashing    (flashing)
    );

    // Palette select by priority; pad_win marks paddle as the visible object
    always_comb begin
        nib     = N_BG;
        pad_win = 1'b0;
        case (mode_q)
            MODE_HANDICAP: begin
                if      (s1.overlay) nib = H_OVL;
                else if (s1.ball)    nib = H_BALL;
                else if (s1.paddle)  begin nib = H_PADDLE; pad_win = 1'b1; end
                else if (s1.wall)    nib = H_WALL;
                else                 nib = H_BG;
            end
            MODE_MONO: begin
                nib     = (s1.ball || s1.paddle || s1.wall) ? M_OBJ : M_BG;
                pad_win = s1.paddle && !s1.ball;
            end
            default: begin
                if      (s1.ball)   nib = N_BALL;
                else if (s1.paddle) begin nib = N_PADDLE; pad_win = 1'b1; end
                else if (s1.wall)   nib = N_WALL;
                else                nib = N_BG;
            end
        endcase
        col_d = expand(nib);
        if (pad_win && flashing) col_d = ~col_d;
        if (!vld_pipe[1])        col_d = '0;
    end

    // Stage 2: final colour
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rgb_q <= '0;
        else        rgb_q <= col_d;
    end

    assign bus.rgb         = rgb_q;
    assign bus.rgb_valid   = vld_pipe[STAGES];
    assign bus.mode_active = mode_q;
    assign bus.flashing    = flashing;

endmodule

// File: tb/tb_pong_pixel_pipe.sv
// Self-checking bench for pong_pixel_pipe: directed scenarios plus random
// pixels against a rule-level colour model.
module tb_pong_pixel_pipe;
    localparam int CW = 4;
    localparam int FF = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // model state
    int exp_mode = 0;
    int flash_left = 0;
    int m_pdy = 300, m_bx = 200, m_by = 100;

    pong_pixel_pipe_if #(.CW(CW)) bus ();
    pong_pixel_pipe_if #(.CW(CW)) bus0 ();

    pong_pixel_pipe #(.CW(CW), .FLASH_FRAMES(FF)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    pong_pixel_pipe #(.CW(CW), .FLASH_FRAMES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));

    assign bus0.pixel_x     = bus.pixel_x;
    assign bus0.pixel_y     = bus.pixel_y;
    assign bus0.video_on    = bus.video_on;
    assign bus0.frame_start = bus.frame_start;
    assign bus0.mode_req    = bus.mode_req;
    assign bus0.hit         = bus.hit;
    assign bus0.paddle_y    = bus.paddle_y;
    assign bus0.ball_x      = bus.ball_x;
    assign bus0.ball_y      = bus.ball_y;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // nibble -> CW bits: {v,v} shifted down keeps the top CW bits
    function automatic logic [3*CW-1:0] widen(input logic [11:0] n);
        logic [35:0] r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            int v = (n >> (ch*4)) & 15;
            int d = (v * 17) >> (8 - CW);
            r = r | (36'(d) << (ch*CW));
        end
        return r[3*CW-1:0];
    endfunction

    function automatic logic [3*CW-1:0] model(input int x, input int y, input bit v);
        bit ball = x >= m_bx && x <= m_bx + 8 && y >= m_by && y <= m_by + 8;
        bit pad  = x >= 600 && x <= 603 && y >= m_pdy && y <= m_pdy + 72;
        bit wall = x >= 32 && x <= 35;
        bit ovl  = x >= 100 && x <= 400;
        bit fl   = flash_left > 0;
        logic [11:0] c;
        if (!v) return '0;
        if (exp_mode == 1)
            c = ovl ? 12'hCE0 : ball ? 12'h00F : pad ? (fl ? 12'hFFF : 12'h000)
              : wall ? 12'hFFF : 12'h3C0;
        else if (exp_mode == 2)
            c = ball ? 12'hFFF : pad ? (fl ? 12'h000 : 12'hFFF) : wall ? 12'hFFF : 12'h000;
        else
            c = ball ? 12'hF00 : pad ? (fl ? 12'hF0F : 12'h0F0) : wall ? 12'h00F : 12'hFFF;
        return widen(c);
    endfunction

    task automatic set_objs(input int pdy, input int bx, input int by);
        m_pdy = pdy; m_bx = bx; m_by = by;
        bus.paddle_y = 10'(pdy); bus.ball_x = 10'(bx); bus.ball_y = 10'(by);
    endtask

    task automatic pulse(input bit h, input bit f);
        bus.hit = h; bus.frame_start = f;
        tick();
        bus.hit = 0; bus.frame_start = 0;
        if (h && FF > 0)               flash_left = FF;
        else if (f && flash_left > 0)  flash_left--;
        if (f && bus.mode_req != 2'b11) exp_mode = int'(bus.mode_req);
    endtask

    task automatic pix(input int x, input int y, input bit v, input string tag);
        bus.pixel_x = 10'(x); bus.pixel_y = 10'(y); bus.video_on = v;
        tick();
        tick();
        check(tag, 36'(bus.rgb), 36'(model(x, y, v)));
        check({tag, "_vld"}, 36'(bus.rgb_valid), 36'(v));
    endtask

    initial begin
        bus.pixel_x = 0; bus.pixel_y = 0; bus.video_on = 1; bus.frame_start = 0;
        bus.mode_req = 0; bus.hit = 0;
        set_objs(300, 200, 100);
        #12;
        check("rst_rgb",  36'(bus.rgb), 0);
        check("rst_vld",  36'(bus.rgb_valid), 0);
        check("rst_flash", 36'(bus.flashing), 0);
        check("rst_mode", 36'(bus.mode_active), 0);
        reset = 1'b1;

        // basic NORMAL ball hits, inclusive right edge
        pix(204, 104, 1, "n_ball_mid");
        pix(208, 108, 1, "n_ball_edge");
        pix(209, 108, 1, "n_ball_out");
        pix(33, 10, 1, "n_wall");
        pix(601, 300, 1, "n_pad");
        pix(601, 373, 1, "n_pad_below");
        pix(204, 104, 0, "n_blank");
        // ball near the right screen edge must not wrap to column 0
        set_objs(300, 1020, 100);
        pix(1023, 104, 1, "wrap_in");
        pix(2, 104, 1, "wrap_out");
        set_objs(300, 200, 100);

        // latency: one edge after a change rgb still shows the old pixel
        pix(204, 104, 1, "lat_a");
        bus.pixel_x = 10'd500;
        tick();
        check("lat_1cyc", 36'(bus.rgb), 36'(model(204, 104, 1)));
        tick();
        check("lat_2cyc", 36'(bus.rgb), 36'(model(500, 104, 1)));

        // flash: high after hit, low after the 8th frame
        pulse(1, 0);
        check("fl_on", 36'(bus.flashing), 1);
        check("fl0_off", 36'(bus0.flashing), 0);
        pix(600, 300, 1, "fl_pad");
        for (int i = 1; i <= FF; i++) begin
            pulse(0, 1);
            check($sformatf("fl_frame%0d", i), 36'(bus.flashing), 36'(i < FF));
        end

        // hit coinciding with 3rd frame reloads
        pulse(1, 0);
        pulse(0, 1);
        pulse(0, 1);
        pulse(1, 1);
        check("rl_on", 36'(bus.flashing), 1);
        check("rl_fl0", 36'(bus0.flashing), 0);
        for (int i = 1; i <= FF; i++) begin
            pulse(0, 1);
            check($sformatf("rl_frame%0d", i), 36'(bus.flashing), 36'(i < FF));
        end

        // mode change only at frame_start; 11 ignored
        bus.mode_req = 2'b01;
        tick(); tick();
        check("mode_hold", 36'(bus.mode_active), 0);
        pulse(0, 1);
        check("mode_hc", 36'(bus.mode_active), 1);
        set_objs(300, 150, 50);
        pix(150, 50, 1, "hc_ovl_ball");
        pix(33, 0, 1, "hc_wall");
        pix(500, 0, 1, "hc_bg");
        bus.mode_req = 2'b11;
        pulse(0, 1);
        check("mode_11", 36'(bus.mode_active), 1);

        // random pixels across modes and flash states
        for (int m = 0; m < 3; m++) begin
            for (int fl = 0; fl < 2; fl++) begin
                bus.mode_req = 2'(m);
                pulse(0, 1);
                for (int k = 0; k < 20 && flash_left > 0; k++) pulse(0, 1);
                if (fl == 1) pulse(1, 0);
                check("rnd_mode", 36'(bus.mode_active), 36'(m));
                check("rnd_flash", 36'(bus.flashing), 36'(fl));
                for (int n = 0; n < 40; n++) begin
                    int x, y, sel;
                    set_objs($urandom_range(0, 1023), $urandom_range(0, 1023),
                             $urandom_range(0, 1023));
                    sel = $urandom_range(0, 3);
                    y = (sel == 2) ? m_pdy + $urandom_range(0, 75) - 2 : m_by + $urandom_range(0, 11) - 2;
                    x = (sel == 0) ? $urandom_range(0, 1023)
                      : (sel == 1) ? m_bx + $urandom_range(0, 11) - 2
                      : (sel == 2) ? $urandom_range(598, 605) : $urandom_range(30, 37);
                    x = x & 1023; y = y & 1023;
                    pix(x, y, $urandom_range(0, 7) != 0, $sformatf("rnd_m%0d_f%0d", m, fl));
                end
            end
        end

        // asynchronous reset mid-flash, mid-frame
        bus.mode_req = 2'b01;
        pulse(0, 1);
        pulse(1, 0);
        set_objs(300, 200, 100);
        pix(601, 310, 1, "pre_rst");
        #3 reset = 1'b0;
        #1;
        flash_left = 0; exp_mode = 0;
        check("arst_rgb", 36'(bus.rgb), 0);
        check("arst_flash", 36'(bus.flashing), 0);
        check("arst_mode", 36'(bus.mode_active), 0);
        check("arst_vld", 36'(bus.rgb_valid), 0);
        tick();
        #2 reset = 1'b1;
        tick();
        check("post_rst_vld1", 36'(bus.rgb_valid), 0);
        tick();
        check("post_rst_vld2", 36'(bus.rgb_valid), 1);
        check("post_rst_rgb", 36'(bus.rgb), 36'(model(601, 310, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pong_pixel_pipe.md
PONG_PIXEL_PIPE -- requirements
Module: pong_pixel_pipe

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- CW, 4: bits per colour channel; legal range 4..8.
- PADDLE_H, 72: paddle height in pixels.
- BALL_W, 8: ball width in pixels.
- BALL_H, 8: ball height in pixels.
- WALL_X0, 32 and WALL_X1, 35: inclusive wall column span.
- PAD_X0, 600 and PAD_X1, 603: inclusive paddle column span.
- HC_X0, 100 and HC_X1, 400: inclusive handicap overlay span.
- FLASH_FRAMES, 8: frames the paddle flashes after a hit.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: the only clock.
- reset, in, 1: asynchronous, active-low.
- pixel_x, in, 10: current pixel column.
- pixel_y, in, 10: current pixel row.
- video_on, in, 1: visible region.
- frame_start, in, 1: one-cycle pulse at the start of each frame.
- mode_req, in, 2: requested mode (00 NORMAL, 01 HANDICAP, 10 MONO).
- hit, in, 1: one-cycle pulse on ball/paddle contact.
- paddle_y, in, 10: paddle top row.
- ball_x, in, 10: ball left column.
- ball_y, in, 10: ball top row.
- rgb, out, 3*CW: pixel colour as {R,G,B}.
- rgb_valid, out, 1: video_on delayed to align with rgb.
- mode_active, out, 2: the mode currently applied.
- flashing, out, 1: high while paddle flash is active.

Function
REQ-003 Pipeline SHALL be two stages: stage 1 registers the region flags (wall, paddle, ball, overlay) and video_on; stage 2 registers rgb and rgb_valid. Latency from pixel_x/pixel_y to rgb SHALL be exactly 2 cycles.
REQ-004 All bounds SHALL be inclusive. paddle_y+PADDLE_H, ball_x+BALL_W and ball_y+BALL_H SHALL be computed in 11 bits so they cannot wrap. Example: ball_x=1020 covers columns 1020..1023 only.
REQ-005 Colours SHALL be defined as 4-bit nibbles per channel. Each nibble SHALL be expanded to CW bits by repeating it MSB-first and truncating, so F gives all ones and 0 gives zero.
REQ-006 When the stage-1 video_on is 0, rgb SHALL be 0.
REQ-007 Priority in NORMAL mode SHALL be ball > paddle > wall > background, with ball F00, paddle 0F0, wall 00F, background FFF.
REQ-008 Priority in HANDICAP mode SHALL be overlay > ball > paddle > wall > background, with overlay CE0, ball 00F, paddle 000, wall FFF, background 3C0. The ball SHALL be hidden inside the overlay.
REQ-009 In MONO mode, background SHALL be 000 and any object SHALL be FFF.
REQ-010 mode_active SHALL load mode_req only on frame_start, so the mode never changes mid-frame. mode_req=11 SHALL be ignored and the previous mode kept.
REQ-011 The flash FSM SHALL have two states, IDLE and FLASH, with an internal frame counter flash_cnt.
- IDLE with hit: go to FLASH and set flash_cnt=FLASH_FRAMES.
- FLASH with frame_start: decrement flash_cnt; on reaching 0, return to IDLE.
- hit while in FLASH: reload flash_cnt to FLASH_FRAMES.
- hit and frame_start in the same cycle: the reload wins and there is no decrement.
REQ-012 flashing SHALL equal (state==FLASH). While flashing, the paddle colour SHALL be the bitwise NOT of its mode colour. The flash SHALL apply in all modes.
REQ-013 With FLASH_FRAMES=0, hit SHALL have no effect and the FSM SHALL stay in IDLE.

Reset
REQ-014 While reset=0, the block SHALL asynchronously clear all state:
- rgb=0, rgb_valid=0, flashing=0.
- mode_active=NORMAL, FSM=IDLE, flash_cnt=0.
- stage-1 registers=0.
REQ-015 Reset asserted mid-frame or mid-flash SHALL abort the flash. The first valid rgb SHALL appear 2 cycles after reset deasserts.

Structure
REQ-016 The mode encodings, FSM state encodings and default colour nibbles SHALL live in a shared package, pong_pkg.
REQ-017 The flash FSM and counter SHALL be one sub-module, pong_flash_ctrl (ports: clk, reset, hit, frame_start, flashing). Region compare and colour mux SHALL remain in pong_pixel_pipe.

Verification
REQ-018 NORMAL mode, defaults: ball_x=200, ball_y=100, pixel (204,104), video_on=1 -> rgb=F00 two cycles later with rgb_valid=1. Pixel (208,108) -> F00; pixel (209,108) -> FFF.
REQ-019 Set mode_req=01 mid-frame -> mode_active stays NORMAL until frame_start, then becomes HANDICAP. Ball at (150,50), pixel (150,50) -> CE0. Pixel (33,0) -> FFF.
REQ-020 Pulse hit, then apply 8 frame_start pulses -> flashing goes high the cycle after hit and low the cycle after the 8th pulse. Paddle pixel (600,paddle_y) -> F0F in NORMAL mode while flashing.
REQ-021 Pulse hit at the same cycle as the 3rd frame_start -> flash_cnt reloads to 8 and 8 further frame_start pulses are needed to clear flashing.
REQ-022 Drive reset low during a flash with video_on=1 -> rgb=0, flashing=0, mode_active=00 immediately, without waiting for clk. After reset releases, rgb_valid is 0 for 2 cycles.
